// File: rtl/spi_master_ctrl_if.sv
// Bundles the system-side handshake/configuration signals and the SPI pins of spi_master_ctrl.
// The slave modport is the controller's view; master is the view of whatever drives it.
`timescale 1ns/1ps
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CS_NUM = 4,
  parameter int DIV_W  = 8
);
  localparam int SEL_W = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;

  logic              start_i;
  logic [DATA_W-1:0] data_in_bi;
  logic              cpol_i;
  logic              cpha_i;
  logic [DIV_W-1:0]  clk_div_bi;
  logic [SEL_W-1:0]  cs_sel_bi;
  logic              abort_i;
  logic              ready_o;
  logic              done_o;
  logic [DATA_W-1:0] data_out_bo;
  logic              spi_miso_i;
  logic              spi_mosi_o;
  logic              spi_sclk_o;
  logic [CS_NUM-1:0] spi_cs_o;

  modport master (
    output start_i, data_in_bi, cpol_i, cpha_i, clk_div_bi, cs_sel_bi, abort_i, spi_miso_i,
    input  ready_o, done_o, data_out_bo, spi_mosi_o, spi_sclk_o, spi_cs_o
  );

  modport slave (
    input  start_i, data_in_bi, cpol_i, cpha_i, clk_div_bi, cs_sel_bi, abort_i, spi_miso_i,
    output ready_o, done_o, data_out_bo, spi_mosi_o, spi_sclk_o, spi_cs_o
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: run-time CPOL/CPHA, programmable SCLK half-period H = div+1, active-low chip selects.
// Busy for (2*DATA_W+2)*H cycles per word; start while busy is dropped, abort returns to idle next edge.
`timescale 1ns/1ps
module spi_master_ctrl #(
  parameter int DATA_W    = 8,
  parameter int CS_NUM    = 4,
  parameter int DIV_W     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  spi_master_ctrl_if.slave bus
);
  localparam int SEL_W = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;
  localparam int HC_W  = $clog2(2 * DATA_W);
  localparam logic [HC_W-1:0] LAST_HALF  = HC_W'(2 * DATA_W - 1);
  localparam logic [HC_W-1:0] LAST_DRIVE = HC_W'(2 * DATA_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HC_W-1:0]   hc_q, hc_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CS_NUM-1:0] cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    if (LSB_FIRST != 0) return w[0];
    return w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w);
    if (LSB_FIRST != 0) return w >> 1;
    return w << 1;
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] w, input logic b);
    if (LSB_FIRST != 0) return {b, w[DATA_W-1:1]};
    return {w[DATA_W-2:0], b};
  endfunction

  // Out-of-range selects leave every line high so the word clocks out as dummy cycles.
  function automatic logic [CS_NUM-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    logic [CS_NUM-1:0] cs;
    cs = '1;
    for (int i = 0; i < CS_NUM; i++) begin
      if (int'(sel) == i) cs[i] = 1'b0;
    end
    return cs;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    hc_d    = hc_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          state_d = S_SETUP;
          ready_d = 1'b0;
          cs_d    = cs_decode(bus.cs_sel_bi);
          sclk_d  = bus.cpol_i;
          cpol_d  = bus.cpol_i;
          cpha_d  = bus.cpha_i;
          div_d   = bus.clk_div_bi;
          cnt_d   = bus.clk_div_bi;
          rx_d    = '0;
          if (bus.cpha_i) begin
            mosi_d = 1'b0;
            tx_d   = bus.data_in_bi;
          end else begin
            mosi_d = first_bit(bus.data_in_bi);
            tx_d   = shift_tx(bus.data_in_bi);
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_XFER;
          cnt_d   = div_q;
          hc_d    = '0;
          sclk_d  = ~sclk_q;
          if (cpha_q) begin
            mosi_d = first_bit(tx_q);
            tx_d   = shift_tx(tx_q);
          end else begin
            rx_d = shift_rx(rx_q, bus.spi_miso_i);
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_XFER: begin
        if (cnt_q == '0) begin
          cnt_d = div_q;
          if (hc_q == LAST_HALF) begin
            state_d = S_HOLD;
          end else begin
            hc_d   = hc_q + HC_W'(1);
            sclk_d = ~sclk_q;
            // The half-period being entered is hc_q+1; it starts on a leading edge when that index is even.
            if (hc_q[0]) begin
              if (cpha_q) begin
                mosi_d = first_bit(tx_q);
                tx_d   = shift_tx(tx_q);
              end else begin
                rx_d = shift_rx(rx_q, bus.spi_miso_i);
              end
            end else begin
              if (cpha_q) begin
                rx_d = shift_rx(rx_q, bus.spi_miso_i);
              end else if (hc_q != LAST_DRIVE) begin
                mosi_d = first_bit(tx_q);
                tx_d   = shift_tx(tx_q);
              end
            end
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cs_d    = '1;
          mosi_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
          dout_d  = rx_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cs_d    = '1;
      sclk_d  = cpol_q;
      mosi_d  = 1'b0;
      ready_d = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      hc_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cs_q    <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      hc_q    <= hc_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
    end
  end

  assign bus.ready_o     = ready_q;
  assign bus.done_o      = done_q;
  assign bus.data_out_bo = dout_q;
  assign bus.spi_mosi_o  = mosi_q;
  assign bus.spi_sclk_o  = sclk_q;
  assign bus.spi_cs_o    = cs_q;
endmodule
